// File: rtl/ram_bus_arbiter_pkg.sv
// rtl/ram_bus_arbiter_pkg.sv - shared RAM bus constants and arbiter types
package ram_bus_arbiter_pkg;

    typedef enum logic {
        MODE_READ  = 1'b0,
        MODE_WRITE = 1'b1
    } bus_mode_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    // In-flight transaction tag carried alongside the RAM access
    typedef struct packed {
        logic is_read;
        logic port;
    } tag_t;

endpackage

// File: rtl/ram_bus_arbiter_if.sv
// rtl/ram_bus_arbiter_if.sv - requester handshakes and RAM port bundle for the arbiter
interface ram_bus_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req0_valid;
    logic              req0_we;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              req0_ready;
    logic              req0_rvalid;

    logic              req1_valid;
    logic              req1_we;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              req1_ready;
    logic              req1_rvalid;

    logic [DATA_W-1:0] rdata;

    logic              ram_bus_mode;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_write_data;
    logic [DATA_W-1:0] ram_read_data;

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        input  ram_read_data,
        output req0_ready, req0_rvalid, req1_ready, req1_rvalid,
        output rdata, ram_bus_mode, ram_addr, ram_write_data
    );

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        output ram_read_data,
        input  req0_ready, req0_rvalid, req1_ready, req1_rvalid,
        input  rdata, ram_bus_mode, ram_addr, ram_write_data
    );

endinterface

// File: rtl/ram_bus_arbiter_rr_pick2.sv
// rtl/ram_bus_arbiter_rr_pick2.sv - combinational two-way grant pick (round-robin or fixed priority)
module rr_pick2 #(
    parameter int FIXED_PRIO = 0
) (
    input  logic valid0,
    input  logic valid1,
    input  logic ptr,
    input  logic force1,
    output logic gnt0,
    output logic gnt1
);

    logic prefer1;

    // Only the tie case consults the preference; a lone requester always wins
    assign prefer1 = (FIXED_PRIO != 0) ? force1 : (ptr | force1);

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (valid0 && valid1) begin
            gnt1 = prefer1;
            gnt0 = ~prefer1;
        end else begin
            gnt0 = valid0;
            gnt1 = valid1;
        end
    end

endmodule

// File: rtl/ram_bus_arbiter.sv
// rtl/ram_bus_arbiter.sv - two-port pipelined arbiter in front of the single-port RAM wrapper
module ram_bus_arbiter
    import ram_bus_arbiter_pkg::*;
#(
    parameter int FIXED_PRIO = 0,
    parameter int STARVE_MAX = 8,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    ram_bus_arbiter_if.slave  bus
);

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    logic              ptr_q, ptr_d;
    logic [7:0]        starve_q, starve_d;
    logic              mode_q, mode_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    tag_t              tag1_q, tag1_d;
    tag_t              tag2_q, tag2_d;

    logic v0, v1, force_p1, gnt0, gnt1, accept, sel_we;

    // Masking valids keeps both ready low for the whole reset window
    assign v0       = bus.req0_valid & ~reset;
    assign v1       = bus.req1_valid & ~reset;
    assign force_p1 = (FIXED_PRIO != 0) && (starve_q == STARVE_LIM);

    rr_pick2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_pick (
        .valid0 (v0),
        .valid1 (v1),
        .ptr    (ptr_q),
        .force1 (force_p1),
        .gnt0   (gnt0),
        .gnt1   (gnt1)
    );

    assign accept = gnt0 | gnt1;
    assign sel_we = gnt1 ? bus.req1_we : bus.req0_we;

    always_comb begin
        ptr_d    = ptr_q;
        starve_d = starve_q;
        mode_d   = MODE_READ;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        tag1_d   = '{is_read: accept & ~sel_we, port: gnt1};
        tag2_d   = tag1_q;

        if (accept) begin
            ptr_d   = ~gnt1;
            addr_d  = gnt1 ? bus.req1_addr  : bus.req0_addr;
            wdata_d = gnt1 ? bus.req1_wdata : bus.req0_wdata;
            mode_d  = sel_we ? MODE_WRITE : MODE_READ;
        end

        if (!bus.req1_valid || gnt1) begin
            starve_d = 8'd0;
        end else if (starve_q != STARVE_LIM) begin
            starve_d = starve_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q    <= PORT_CPU;
            starve_q <= 8'd0;
            mode_q   <= MODE_READ;
            addr_q   <= '0;
            wdata_q  <= '0;
            tag1_q   <= '0;
            tag2_q   <= '0;
        end else begin
            ptr_q    <= ptr_d;
            starve_q <= starve_d;
            mode_q   <= mode_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            tag1_q   <= tag1_d;
            tag2_q   <= tag2_d;
        end
    end

    assign bus.req0_ready     = gnt0;
    assign bus.req1_ready     = gnt1;
    assign bus.req0_rvalid    = tag2_q.is_read && (tag2_q.port == PORT_CPU);
    assign bus.req1_rvalid    = tag2_q.is_read && (tag2_q.port == PORT_AUX);
    assign bus.rdata          = bus.ram_read_data;
    assign bus.ram_bus_mode   = mode_q;
    assign bus.ram_addr       = addr_q;
    assign bus.ram_write_data = wdata_q;

endmodule

// File: doc/ram_bus_arbiter.md
Name: ram_bus_arbiter

Overview:
- Shares the single 1K-word RAM port (ram_bus_mode / ram_addr / ram_write_data / ram_read_data) between two requesters: port 0 is the CPU, port 1 is an auxiliary master (DMA / display fetch).
- Accepts at most one transaction per cycle, fully pipelined, and returns read data to the requester that issued it.
- Sits between the CPU/aux masters and the RAM wrapper. The RAM wrapper itself is unchanged.

Parameters:
- FIXED_PRIO, 0, 0 = round-robin between ports; 1 = port 0 has fixed priority, with a starvation guard for port 1.
- STARVE_MAX, 8, in FIXED_PRIO mode, the number of consecutive cycles port 1 may be denied while requesting; the next grant then goes to port 1. Range 1..255.
- ADDR_W, 16, address width.
- DATA_W, 16, data width.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- req0_valid  in  1  port 0 request.
- req0_we  in  1  1 = write, 0 = read.
- req0_addr  in  ADDR_W  port 0 address.
- req0_wdata  in  DATA_W  port 0 write data.
- req0_ready  out  1  combinational accept; a transaction transfers on the edge where valid && ready.
- req0_rvalid  out  1  one-cycle pulse; rdata is valid for port 0.
- req1_valid, req1_we, req1_addr, req1_wdata, req1_ready, req1_rvalid  same as port 0, for port 1.
- rdata  out  DATA_W  shared read data, driven directly from ram_read_data.
- ram_bus_mode  out  1  registered; MODE_WRITE / MODE_READ.
- ram_addr  out  ADDR_W  registered.
- ram_write_data  out  DATA_W  registered.
- ram_read_data  in  DATA_W  from RAM; synchronous, valid the cycle after the address edge.

Interface decision:
- One clock: clk. Reset: reset, synchronous and active-high.

Behaviour:
- Grant (combinational, each cycle):
  - Exactly one of req0_ready / req1_ready may be high.
  - ready is high only if the matching valid is high and that port wins arbitration.
  - With neither valid, both ready are 0.
- Round-robin (FIXED_PRIO=0):
  - Pointer ptr holds the preferred port. Reset value is 0.
  - Both valid: grant ptr. After any grant, ptr <= ~granted port.
  - Only one valid: grant it, and ptr updates as above.
- Fixed priority (FIXED_PRIO=1):
  - Port 0 wins ties.
  - starve_cnt (8-bit) increments while req1_valid && !req1_ready, saturating at STARVE_MAX.
  - It clears when port 1 is granted or req1_valid is low.
  - starve_cnt == STARVE_MAX forces the grant to port 1 even if port 0 is valid.
- Issue stage (registered at the accept edge E0):
  - ram_addr <= addr, ram_write_data <= wdata.
  - ram_bus_mode <= MODE_WRITE if we, else MODE_READ.
- Idle cycles:
  - ram_bus_mode <= MODE_READ; ram_addr and ram_write_data hold.
  - A write is never repeated: MODE_WRITE lasts exactly one cycle per accepted write.
- Read return:
  - Tag pipeline of 2 stages holds {is_read, port}.
  - Stage 1 loads at E0; stage 2 loads at E1, when the RAM samples the address.
  - reqN_rvalid = stage2.is_read && stage2.port == N, registered. It is high in the cycle after E1, together with ram_read_data.
  - Accept-to-rvalid latency: 2 cycles.
  - Back-to-back reads from alternating ports return in issue order, one per cycle.
- Writes: no response; complete at E1.
- Read-after-write to the same address on consecutive accepts returns the new data, since the RAM is write-first by sequencing.
- Reset values:
  - ram_bus_mode = MODE_READ, ram_addr = 0, ram_write_data = 0.
  - Both rvalid = 0, tag pipeline cleared, ptr = 0, starve_cnt = 0.
- Reset mid-operation:
  - In-flight reads are dropped; no rvalid follows reset.
  - A write registered on the edge before reset still lands in RAM at the reset edge. This is accepted behaviour.
  - While reset is high, both ready = 0.
- Requester rules: a requester must hold valid, we, addr and wdata stable until ready. Dropping valid without ready is legal and has no effect.

Decomposition:
- Shared constants file (existing): MODE_WRITE / MODE_READ.
- Add to the same file: PORT_CPU = 0, PORT_AUX = 1.
- One sub-module, rr_pick2: takes the two valids, ptr, the starvation force and FIXED_PRIO, and returns the grant. It is purely combinational.
- The top level holds ptr, starve_cnt, the issue registers and the tag pipeline.

Test Plan:
- Reset then idle, 5 cycles:
  - ram_bus_mode = MODE_READ, ram_addr = 0, no ready, no rvalid.
- Port 0 writes 0x1234 to addr 0x005; port 0 reads 0x005 next cycle:
  - MODE_WRITE exactly 1 cycle.
  - req0_rvalid 2 cycles after the read accept, with rdata = 0x1234.
- Round-robin, both ports reading continuously for 6 cycles:
  - Grants alternate 0,1,0,1,0,1.
  - rvalid alternates port 0 / port 1 with matching data.
- FIXED_PRIO=1, STARVE_MAX=3, both ports valid throughout:
  - Port 0 granted 3 cycles, then port 1 granted once, then port 0 again.
- Reset asserted one cycle after a read accept:
  - No rvalid is ever produced; ready is 0 during reset.
  - Normal operation resumes with ptr = 0.
- Port 1 writes addr 0x3FF = 0xBEEF while port 0 is idle; port 0 then reads 0x3FF:
  - rdata = 0xBEEF; ram_addr wraps correctly in the 10-bit RAM.
